ahb_lite_sram_slave: RTL and testbench

AHB-Lite slave that terminates transfers from the team's AHB-Lite master interface and backs them with an internal word-organised register memory. It is the responder end of the bus: it samples the address phase, completes the data phase after a configurable number of wait states, and drives `hreadyout`, `hresp` and `hrdata`. It returns a two-cycle ERROR response for illegal accesses. Both the UVM environment and the standalone demos use it as the default slave model.

---
 rtl/ahb_lite_sram_slave.sv | 138 +++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a word-organised register memory.
// Legal beats complete after WAIT_STATES wait cycles; illegal beats get a two-cycle ERROR.
module ahb_lite_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hwrite,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          AW         = $clog2(MEM_DEPTH);
    localparam logic [31:0] BYTE_LIMIT = 32'(MEM_DEPTH * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic [31:0]   mem [MEM_DEPTH];

    logic          accept;
    logic          illegal;
    logic [3:0]    lane_en;
    logic          unused_inputs;

    // Burst type and lock are irrelevant: every beat is handled on its own.
    assign unused_inputs = ^{hburst, hmastlock, htrans[0]};

    assign accept = hsel & hready & htrans[1];

    always_comb begin
        illegal = 1'b0;
        if (haddr >= BYTE_LIMIT)                         illegal = 1'b1;
        if (hsize > 3'b010)                              illegal = 1'b1;
        if (hsize == 3'b001 && haddr[0])                 illegal = 1'b1;
        if (hsize == 3'b010 && haddr[1:0] != 2'b00)      illegal = 1'b1;
    end

    always_comb begin
        lane_en = 4'b1111;
        case (size_q)
            2'b00:   lane_en = 4'b0001 << addr_q[1:0];
            2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // hreadyout/hresp are registered: they are loaded together with the state
    // they belong to, so the bus never sees a combinational glitch on them.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= S_LAST;
                        cnt       <= '0;
                        hreadyout <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    // IDLE, LAST and ERR2 all accept the next address phase
                    if (accept) begin
                        addr_q  <= haddr[AW+1:0];
                        write_q <= hwrite;
                        size_q  <= hsize[1:0];
                        if (illegal) begin
                            state     <= S_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state     <= S_LAST;
                            hreadyout <= 1'b1;
                            hresp     <= 1'b0;
                        end else begin
                            state     <= S_WAIT;
                            cnt       <= 4'(WAIT_STATES);
                            hreadyout <= 1'b0;
                            hresp     <= 1'b0;
                        end
                    end else begin
                        state     <= S_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // NOTE: the memory array has no reset; clearing it would turn it into a
    // huge reset fan-out for no functional benefit, its contents start undefined.
    always_ff @(posedge hclk) begin
        if (state == S_LAST && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    // Combinational read lets a read directly after a write see the new data.
    assign hrdata = (state == S_LAST) ? mem[addr_q[AW+1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: one slave with one wait state (sequential transfers, random traffic)
// and one zero-wait slave (pipelined transfers), both checked against byte/word memory models.
module tb_ahb_lite_sram_slave;

    localparam int MEM_BYTES = 256 * 4;
    localparam int WS_A      = 1;

    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    // slave A: WAIT_STATES = 1
    logic        hsel_a, hwrite_a, hreadyout_a, hresp_a;
    logic [31:0] haddr_a, hwdata_a, hrdata_a;
    logic [1:0]  htrans_a;
    logic [2:0]  hsize_a;
    // slave B: WAIT_STATES = 0
    logic        hsel_b, hwrite_b, hreadyout_b, hresp_b;
    logic [31:0] haddr_b, hwdata_b, hrdata_b;
    logic [1:0]  htrans_b;
    logic [2:0]  hsize_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_a [MEM_BYTES];
    logic [31:0] model_b [int];

    ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(WS_A)) dut_a (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a), .haddr(haddr_a), .htrans(htrans_a),
        .hsize(hsize_a), .hburst(3'b000), .hwrite(hwrite_a), .hmastlock(1'b0),
        .hwdata(hwdata_a), .hready(hreadyout_a), .hreadyout(hreadyout_a), .hresp(hresp_a),
        .hrdata(hrdata_a)
    );

    ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b), .haddr(haddr_b), .htrans(htrans_b),
        .hsize(hsize_b), .hburst(3'b001), .hwrite(hwrite_b), .hmastlock(1'b0),
        .hwdata(hwdata_b), .hready(hreadyout_b), .hreadyout(hreadyout_b), .hresp(hresp_b),
        .hrdata(hrdata_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic is_legal(input logic [31:0] addr, input logic [2:0] size);
        if (addr >= 32'(MEM_BYTES)) return 1'b0;
        if (size > 3'd2) return 1'b0;
        if (size == 3'd1 && addr % 2 != 0) return 1'b0;
        if (size == 3'd2 && addr % 4 != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read_a(input logic [31:0] addr);
        int base;
        base = int'(addr) - int'(addr % 4);
        return {model_a[base+3], model_a[base+2], model_a[base+1], model_a[base]};
    endfunction

    // Little-endian byte memory: byte at address b travels on lane b%4.
    task automatic model_write_a(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        int nbytes, base, b;
        nbytes = 1 << size;
        base   = int'(addr) - int'(addr % nbytes);
        for (int k = 0; k < nbytes; k++) begin
            b = base + k;
            model_a[b] = data[8*(b%4) +: 8];
        end
    endtask

    task automatic idle_a();
        hsel_a = 1'b0; htrans_a = 2'b00; haddr_a = '0; hsize_a = 3'b010; hwrite_a = 1'b0;
    endtask

    task automatic idle_b();
        hsel_b = 1'b0; htrans_b = 2'b00; haddr_b = '0; hsize_b = 3'b010; hwrite_b = 1'b0;
    endtask

    // One non-pipelined transfer on slave A, fully checked against the model.
    task automatic xfer_a(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata, output logic [31:0] rd);
        logic lg;
        int   low;
        lg  = is_legal(addr, size);
        low = 0;
        rd  = '0;
        hsel_a = 1'b1; htrans_a = 2'b10; haddr_a = addr; hsize_a = size; hwrite_a = wr;
        @(posedge hclk); #1;
        idle_a();
        hwdata_a = wdata;
        while (hreadyout_a !== 1'b1 && low < 32) begin
            check({tag, " resp_during_wait"}, 32'(hresp_a), lg ? 32'd0 : 32'd1);
            low++;
            @(posedge hclk); #1;
        end
        check({tag, " wait_cycles"}, 32'(low), lg ? 32'(WS_A) : 32'd1);
        check({tag, " resp_final"}, 32'(hresp_a), lg ? 32'd0 : 32'd1);
        rd = hrdata_a;
        if (!wr && lg) check({tag, " rdata"}, hrdata_a, model_read_a(addr));
        @(posedge hclk); #1;
        if (wr && lg) model_write_a(addr, size, wdata);
        check({tag, " rdata_idle"}, hrdata_a, 32'h0);
    endtask

    logic [31:0] rd;
    logic [31:0] pa [6];
    logic [31:0] pd [6];
    logic        pw [6];

    initial begin
        hresetn = 1'b0;
        idle_a(); idle_b();
        hwdata_a = '0; hwdata_b = '0;
        repeat (3) @(posedge hclk);
        #1;
        check("reset hreadyout", 32'(hreadyout_a), 32'd1);
        check("reset hresp", 32'(hresp_a), 32'd0);
        check("reset hrdata", hrdata_a, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // IDLE, BUSY and deselected NONSEQ are not accepted: zero-wait OKAY
        hsel_a = 1'b1; hwrite_a = 1'b1; haddr_a = 32'h10; htrans_a = 2'b00;
        @(posedge hclk); #1;
        check("idle hreadyout", 32'(hreadyout_a), 32'd1);
        check("idle hresp", 32'(hresp_a), 32'd0);
        htrans_a = 2'b01;
        @(posedge hclk); #1;
        check("busy hreadyout", 32'(hreadyout_a), 32'd1);
        check("busy hresp", 32'(hresp_a), 32'd0);
        hsel_a = 1'b0; htrans_a = 2'b10;
        @(posedge hclk); #1;
        check("unsel hreadyout", 32'(hreadyout_a), 32'd1);
        idle_a();

        // give the model a known image of the region used by random traffic
        for (int w = 0; w < 64; w++) xfer_a("init", 1'b1, 32'(w * 4), 3'd2, $urandom, rd);
        xfer_a("top_word_wr", 1'b1, 32'h3FC, 3'd2, 32'hA5A5_5A5A, rd);
        xfer_a("top_word_rd", 1'b0, 32'h3FC, 3'd2, 32'h0, rd);

        xfer_a("deadbeef_wr", 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, rd);
        xfer_a("deadbeef_rd", 1'b0, 32'h10, 3'd2, 32'h0, rd);
        check("deadbeef value", rd, 32'hDEAD_BEEF);

        // off-lane bits carry junk so an over-wide lane enable is visible
        xfer_a("lane_word", 1'b1, 32'h20, 3'd2, 32'h1122_3344, rd);
        xfer_a("lane_half", 1'b1, 32'h22, 3'd1, 32'hAAAA_9999, rd);
        xfer_a("lane_byte", 1'b1, 32'h20, 3'd0, 32'h7766_8855, rd);
        xfer_a("lane_rd", 1'b0, 32'h20, 3'd2, 32'h0, rd);
        check("lane value", rd, 32'hAAAA_3355);

        xfer_a("err_misaligned", 1'b0, 32'h1, 3'd2, 32'h0, rd);
        xfer_a("err_range", 1'b1, 32'h400, 3'd2, 32'h1234_5678, rd);
        xfer_a("err_size", 1'b1, 32'h0, 3'd3, 32'hFFFF_FFFF, rd);
        xfer_a("err_half_odd", 1'b1, 32'h3, 3'd1, 32'hFFFF_FFFF, rd);
        xfer_a("err_after_rd", 1'b0, 32'h0, 3'd2, 32'h0, rd);

        // reset during the wait state of a write discards it
        hsel_a = 1'b1; htrans_a = 2'b10; haddr_a = 32'h8; hsize_a = 3'd2; hwrite_a = 1'b1;
        @(posedge hclk); #1;
        idle_a();
        hwdata_a = 32'hCAFE_F00D;
        check("midrst in wait", 32'(hreadyout_a), 32'd0);
        hresetn = 1'b0;
        #1;
        check("midrst hreadyout", 32'(hreadyout_a), 32'd1);
        check("midrst hresp", 32'(hresp_a), 32'd0);
        check("midrst hrdata", hrdata_a, 32'h0);
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer_a("midrst_rd", 1'b0, 32'h8, 3'd2, 32'h0, rd);

        // zero-wait slave: back-to-back address phases, no bubbles
        pw[0] = 1'b1; pa[0] = 32'h0; pd[0] = $urandom;
        pw[1] = 1'b1; pa[1] = 32'h4; pd[1] = $urandom;
        pw[2] = 1'b0; pa[2] = 32'h0; pd[2] = 32'h0;
        pw[3] = 1'b1; pa[3] = 32'h8; pd[3] = $urandom;
        pw[4] = 1'b0; pa[4] = 32'h8; pd[4] = 32'h0;
        pw[5] = 1'b0; pa[5] = 32'h4; pd[5] = 32'h0;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                hsel_b = 1'b1; htrans_b = (i == 1) ? 2'b11 : 2'b10;
                haddr_b = pa[i]; hwrite_b = pw[i]; hsize_b = 3'd2;
            end else begin
                idle_b();
            end
            if (i > 0) begin
                hwdata_b = pd[i-1];
                check("pipe hreadyout", 32'(hreadyout_b), 32'd1);
                check("pipe hresp", 32'(hresp_b), 32'd0);
                if (pw[i-1]) model_b[int'(pa[i-1])] = pd[i-1];
                else check("pipe rdata", hrdata_b, model_b[int'(pa[i-1])]);
            end
            @(posedge hclk); #1;
        end

        // ERROR still takes two cycles on the zero-wait slave
        hsel_b = 1'b1; htrans_b = 2'b10; haddr_b = 32'h6; hsize_b = 3'd2; hwrite_b = 1'b1;
        @(posedge hclk); #1;
        idle_b();
        hwdata_b = 32'hFFFF_FFFF;
        check("b_err1 hreadyout", 32'(hreadyout_b), 32'd0);
        check("b_err1 hresp", 32'(hresp_b), 32'd1);
        @(posedge hclk); #1;
        check("b_err2 hreadyout", 32'(hreadyout_b), 32'd1);
        check("b_err2 hresp", 32'(hresp_b), 32'd1);
        @(posedge hclk); #1;
        check("b_post hresp", 32'(hresp_b), 32'd0);
        hsel_b = 1'b1; htrans_b = 2'b10; haddr_b = 32'h4; hsize_b = 3'd2; hwrite_b = 1'b0;
        @(posedge hclk); #1;
        idle_b();
        check("b_post rdata", hrdata_b, model_b[4]);
        @(posedge hclk); #1;

        // random mix of sizes, alignments, directions and illegal addresses
        for (int n = 0; n < 120; n++) begin
            logic [31:0] addr;
            logic [2:0]  size;
            int          sel;
            sel  = $urandom_range(0, 9);
            if (sel == 0)      addr = 32'h400 + 32'($urandom_range(0, 255));
            else if (sel == 1) addr = $urandom | 32'h8000_0000;
            else               addr = 32'($urandom_range(0, 255));
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            xfer_a("rand", 1'($urandom_range(0, 1)), addr, size, $urandom, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
